// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell iterated over WIDTH cycles,
// producing {carry, sum} with a start/done handshake.
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// SHIFT | one result bit per clock, LSB first; busy=1
// DONE  | sum valid, done=1 for exactly one cycle
module serial_addsub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb;
  logic [WIDTH-2:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit, c_bit, last;

  assign s_bit = opa[0] ^ opb[0] ^ carry;
  assign c_bit = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
  assign last  = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is a + ~b + ~cin, so b is inverted and the borrow flipped at latch time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= cin ^ sub;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          // res holds the WIDTH-1 earlier bits; the final bit goes straight to sum.
          res   <= (WIDTH-1)'({s_bit, res} >> 1);
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= c_bit;
          cnt   <= cnt + 1'b1;
          if (last) sum <= {c_bit, s_bit, res};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: per-cycle comparison against an
// arithmetic model, plus directed cases with literal expected results.
module tb_serial_addsub;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             busy, done;
  logic [WIDTH:0]   sum;

  int n_checks = 0;
  int n_fail   = 0;

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .cin(cin), .sub(sub), .busy(busy), .done(done), .sum(sum)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH:0] ref_result(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                input logic ci, input logic sb);
    int r;
    if (sb) r = int'(x) + (1 << WIDTH) - int'(y) - int'(ci);
    else    r = int'(x) + int'(y) + int'(ci);
    return r[WIDTH:0];
  endfunction

  // Model: an accepted request yields its result WIDTH cycles later, shown for one cycle.
  int             m_left = 0;
  logic           m_done = 1'b0;
  logic [WIDTH:0] m_sum  = '0;
  logic [WIDTH:0] m_pend = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_sum  = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_sum  = m_pend;
        m_done = 1'b1;
      end
    end else if (start) begin
      m_left = WIDTH;
      m_pend = ref_result(a, b, cin, sub);
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_left > 0));
    check("done", 32'(done), 32'(m_done));
    check("sum",  32'(sum),  32'(m_sum));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Must be called while the DUT is idle; returns one tick after done, back in IDLE.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tcin, input logic tsub,
                        input logic [WIDTH:0] exp, input string name);
    int n, nbusy;
    a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
    tick();
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    n = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) nbusy++;
    end while (!done && n < 20);
    check({name, "_latency"}, n, WIDTH + 1);
    check({name, "_busy_cycles"}, nbusy, WIDTH);
    check({name, "_sum"}, 32'(sum), 32'(exp));
    tick();
    check({name, "_done_pulse"}, 32'(done), 0);
  endtask

  initial begin
    int ndone;
    logic [WIDTH:0] seen;
    #1 rst = 1'b1;
    tick(); tick();
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_sum",  32'(sum),  0);
    rst = 1'b0;
    tick();

    run_op(4'b0000, 4'b0000, 1'b0, 1'b0, 5'b00000, "add_zero");
    run_op(4'b0000, 4'b0001, 1'b0, 1'b0, 5'b00001, "add_one");
    run_op(4'b1111, 4'b1111, 1'b1, 1'b0, 5'b11111, "add_max");
    run_op(4'b0101, 4'b0011, 1'b0, 1'b1, 5'b10010, "sub_noborrow");
    run_op(4'b0011, 4'b0101, 1'b0, 1'b1, 5'b01110, "sub_borrow");

    // start pulsed again mid-operation with new operands must be ignored
    a = 4'b0001; b = 4'b0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; a = 4'b1111; b = 4'b0111;
    tick();
    start = 1'b0;
    ndone = 0;
    seen = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        seen = sum;
      end
    end
    check("busy_start_done_count", ndone, 1);
    check("busy_start_sum", 32'(seen), 32'(5'b00010));
    tick();

    // reset in the middle of an operation clears outputs immediately
    a = 4'b1111; b = 4'b0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    check("midreset_busy", 32'(busy), 0);
    check("midreset_done", 32'(done), 0);
    check("midreset_sum",  32'(sum),  0);
    tick(); tick();
    rst = 1'b0;
    tick();
    run_op(4'b0010, 4'b0010, 1'b0, 1'b0, 5'b00100, "after_reset");

    // start held high: back-to-back operations with changing operands
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      tick();
    end
    start = 1'b0;

    // random traffic with occasional asynchronous resets
    for (int i = 0; i < 1500; i++) begin
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      cin   = 1'($urandom);
      sub   = 1'($urandom);
      start = ($urandom_range(0, 2) == 0);
      rst   = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;
    start = 1'b0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial adder/subtractor: computes a+b+cin or a-b-cin using one full-adder cell iterated over WIDTH clock cycles.
- Sequential, area-minimal counterpart to the combinational ripple-carry adder. It produces the same {carry,sum} result format, so the same operand vectors can cross-check both blocks.
- Uses a start/done handshake driven by a bench or controller.

Parameters:
- WIDTH, 4, operand width in bits (must be >= 2).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- busy  output  1  high while an operation is in progress (SHIFT state).
- done  output  1  one-cycle pulse when sum is valid.
- sum  output  WIDTH+1  result; bit WIDTH is carry-out (sub: 1 = no borrow).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: busy=0, done=0, sum=0, state=IDLE, bit counter=0, internal shift registers and carry=0.
- FSM states:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1.
  - DONE: done=1 for exactly one cycle, busy=0.
- IDLE, start=1 at edge E0:
  - Latch opA=a.
  - Latch opB = sub ? ~b : b.
  - Latch carry = cin ^ sub.
  - Counter=0; next state SHIFT.
- SHIFT, one bit per edge (edges E1..EW):
  - s = opA[0]^opB[0]^carry; carry = majority(opA[0],opB[0],carry).
  - s is shifted into the result register from the MSB side.
  - opA and opB shift right by one.
  - Counter increments.
  - At edge EW (counter reaches WIDTH-1 → done): sum <= {final carry, WIDTH result bits}; next state DONE.
- Latency: done high in the cycle after edge EW, i.e. WIDTH+1 edges after start is sampled.
- DONE → IDLE unconditionally at the next edge.
- sum holds its value until the next completed operation; it does not change during SHIFT.
- Arithmetic:
  - sub=0: sum = a + b + cin (WIDTH+1 bits, unsigned).
  - sub=1: sum = {no_borrow, (a - b - cin) mod 2^WIDTH}, computed as a + ~b + ~cin.
- start while busy or in DONE is ignored; the operands latched at E0 are used throughout.
- Operand inputs a/b/cin/sub may change freely after E0 with no effect.
- Reset mid-operation aborts immediately:
  - All outputs go to their reset values; no done pulse.
  - The next start after reset deassertion begins a fresh operation.
- start held high continuously: a new operation is accepted on each return to IDLE, giving a period of WIDTH+2 cycles.

Test Plan:
- Add, zero vectors: a=0000,b=0000,cin=0,sub=0, start 1 cycle → done after 5 edges, sum=00000; then a=0000,b=0001 → sum=00001.
- Add, max carry: a=1111,b=1111,cin=1,sub=0 → sum=11111, busy high exactly 4 cycles, done high exactly 1 cycle.
- Subtract, no borrow: a=0101,b=0011,cin=0,sub=1 → sum=1_0010.
- Subtract, borrow: a=0011,b=0101,cin=0,sub=1 → sum=0_1110.
- Start while busy: start a=0001,b=0001 add, pulse start again with a=1111 at edge E2 and change a/b → sum=00010; only one done pulse.
- Reset mid-operation: assert rst at edge E2 of an add 1111+0001 → busy=0, done=0, sum=00000 asynchronously. After release, start 0010+0010 → sum=00100.
